// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the memory responder.
// Range checking is enabled by defining MEM_RANGE_CHECK_EN.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int wait_w(input int ws);
      return (ws < 2) ? 1 : $clog2(ws + 1);
   endfunction

   localparam int DEF_DEPTH = 256;
   localparam int DEF_WAIT  = 1;
   localparam int IDX_W     = idx_w(DEF_DEPTH);
   localparam int WAIT_W    = wait_w(DEF_WAIT);

endpackage

// File: rtl/mem_ram_array.sv
// Word storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_ram_array
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 256,
   parameter int IW         = idx_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IW-1:0]         idx,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] ram [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         ram[idx] <= wdata;
      end
   end

   assign rdata = ram[idx];

endmodule

// File: rtl/mem_responder.sv
// Single-word memory responder with programmable wait states.
// Define MEM_RANGE_CHECK_EN to flag addresses >= DEPTH via mem_err.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_req,
   input  logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_busy,
   output logic                  mem_done,
   output logic                  mem_err
);

   localparam int IW = idx_w(DEPTH);
   localparam int CW = wait_w(WAIT_STATES);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  we_q;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  commit;
   logic                  ram_we;
   logic                  oor;

   assign commit = (state == ACCESS) && (cnt == '0);

`ifdef MEM_RANGE_CHECK_EN
   localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(DEPTH);
   assign oor = ({1'b0, addr_q} >= DEPTH_V);
`else
   assign oor = 1'b0;
   if (ADDR_WIDTH > IW) begin : g_alias
      // Upper address bits alias away when range checking is off.
      logic unused_hi;
      assign unused_hi = ^addr_q[ADDR_WIDTH-1:IW];
   end
`endif

   // Reset at the commit edge must suppress the write.
   assign ram_we = commit && we_q && !oor && rst_n;

   mem_ram_array #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .IW        (IW)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .idx  (addr_q[IW-1:0]),
      .wdata(wdata_q),
      .rdata(ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         cnt       <= '0;
         mem_rdata <= '0;
         mem_busy  <= 1'b0;
         mem_done  <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         mem_done <= 1'b0;
         mem_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (mem_req) begin
                  addr_q   <= mem_addr;
                  wdata_q  <= mem_wdata;
                  we_q     <= mem_we;
                  cnt      <= CW'(WAIT_STATES);
                  state    <= ACCESS;
                  mem_busy <= 1'b1;
               end
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state    <= DONE;
                  mem_done <= 1'b1;
                  mem_err  <= oor;
                  if (!we_q) begin
                     mem_rdata <= oor ? '0 : ram_rdata;
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               mem_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (1 and 0 wait states) share stimulus.
module tb_mem_responder;

   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic          req = 1'b0;
   logic          we = 1'b0;

   logic [DW-1:0] rdata1, rdata0;
   logic          busy1, busy0, done1, done0, err1, err0;

   mem_responder #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .WAIT_STATES(1)
   ) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_addr (addr),
      .mem_wdata(wdata),
      .mem_req  (req),
      .mem_we   (we),
      .mem_rdata(rdata1),
      .mem_busy (busy1),
      .mem_done (done1),
      .mem_err  (err1)
   );

   mem_responder #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .WAIT_STATES(0)
   ) u_dut0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_addr (addr),
      .mem_wdata(wdata),
      .mem_req  (req),
      .mem_we   (we),
      .mem_rdata(rdata0),
      .mem_busy (busy0),
      .mem_done (done0),
      .mem_err  (err0)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      int            cyc;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t q1[$];
   exp_t q0[$];
   exp_t e1, e0;

   logic [DW-1:0] model [int];
   logic [DW-1:0] rd_model = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (done1) begin
            if (q1.size() == 0) begin
               check("ws1_extra_done", 1, 0);
            end else begin
               e1 = q1.pop_front();
               check("ws1_latency", cyc, e1.cyc);
               check("ws1_rdata", rdata1, e1.rdata);
               check("ws1_err", err1, e1.err);
            end
         end
         if (done0) begin
            if (q0.size() == 0) begin
               check("ws0_extra_done", 1, 0);
            end else begin
               e0 = q0.pop_front();
               check("ws0_latency", cyc, e0.cyc);
               check("ws0_rdata", rdata0, e0.rdata);
               check("ws0_err", err0, e0.err);
            end
         end
      end
   end

   task automatic xfer(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit hold);
      int            s;
      int            idx;
      logic          exp_err;
      logic [DW-1:0] exp_rd;
      exp_err = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      if (int'(a) >= DEPTH) exp_err = 1'b1;
`endif
      idx = int'(a) % DEPTH;
      if (w) begin
         if (!exp_err) model[idx] = d;
      end else begin
         rd_model = exp_err ? '0 : model[idx];
      end
      exp_rd = rd_model;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
      s = cyc;
      q1.push_back('{s + 2, exp_rd, exp_err});
      q0.push_back('{s + 1, exp_rd, exp_err});
      if (hold) begin
         we = 1'b1; addr = a + 1'b1; wdata = 16'h5555;
      end else begin
         req = 1'b0;
      end
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check("ws1_busy", busy1, (n < 3));
         check("ws0_busy", busy0, (n < 2));
         if (n == 2) req = 1'b0;
      end
      #1;
      check("ws1_done_seen", q1.size(), 0);
      check("ws0_done_seen", q0.size(), 0);
      q1.delete();
      q0.delete();
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_rdata1"}, rdata1, 0);
      check({tag, "_busy1"}, busy1, 0);
      check({tag, "_done1"}, done1, 0);
      check({tag, "_err1"}, err1, 0);
      check({tag, "_rdata0"}, rdata0, 0);
      check({tag, "_busy0"}, busy0, 0);
      check({tag, "_done0"}, done0, 0);
      check({tag, "_err0"}, err0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      xfer(1'b1, 16'h0010, 16'hBEEF, 1'b0);
      xfer(1'b0, 16'h0010, 16'h0000, 1'b0);

      xfer(1'b1, 16'h0005, 16'h1234, 1'b0);
      xfer(1'b0, 16'h0005, 16'h0000, 1'b0);

      xfer(1'b1, 16'h0021, 16'h0000, 1'b0);
      xfer(1'b1, 16'h0020, 16'hAAAA, 1'b1);
      xfer(1'b0, 16'h0020, 16'h0000, 1'b0);
      xfer(1'b0, 16'h0021, 16'h0000, 1'b0);

      xfer(1'b1, 16'h0030, 16'h1111, 1'b0);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'h2222;
      @(posedge clk);
      #1;
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_idle_zero("abort");
      @(negedge clk);
      rst_n = 1'b1;
      rd_model = '0;
      repeat (3) @(negedge clk);
      check("abort_no_done1", done1, 0);
      check("abort_no_done0", done0, 0);
      xfer(1'b0, 16'h0030, 16'h0000, 1'b0);

      xfer(1'b1, 16'h0000, 16'h7777, 1'b0);
      xfer(1'b1, 16'h0100, 16'h9999, 1'b0);
      xfer(1'b0, 16'h0000, 16'h0000, 1'b0);

      xfer(1'b1, 16'h0040, 16'hCAFE, 1'b0);
      xfer(1'b0, 16'h0040, 16'h0000, 1'b0);
      xfer(1'b1, 16'h0041, 16'hFFFF, 1'b0);
      repeat (3) @(negedge clk);
      check("hold_rdata1", rdata1, rd_model);
      check("hold_rdata0", rdata0, rd_model);
      check("hold_cafe1", rdata1, 16'hCAFE);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
